// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, read-only cache controller with line-fill handshake and flush.
// Define DM_CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dm_cache_ctrl #(
    parameter int ADDR_W         = 15,
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int LINE_COUNT     = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cpu_read,
    input  logic [ADDR_W-1:0]                cpu_addr,
    output logic [WORD_W-1:0]                cpu_data,
    output logic                             cpu_ready,
    output logic                             hit,
    input  logic                             flush,
    output logic                             busy,
    output logic                             mem_read,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic                             mem_ready,
    input  logic [WORDS_PER_LINE*WORD_W-1:0] mem_line
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0]                      hit_count,
    output logic [31:0]                      miss_count
`endif
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINE_COUNT);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_FILL,
        S_RESPOND
    } state_t;

    state_t                r_state;
    line_t                 r_dataArray [LINE_COUNT];
    logic [TAG_W-1:0]      r_tagArray  [LINE_COUNT];
    logic [LINE_COUNT-1:0] r_valid;
    logic [ADDR_W-1:0]     r_addr;
    logic [WORD_W-1:0]     r_fillWord;

    logic [OFF_W-1:0]      w_off;
    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    line_t                 w_memWords;
    line_t                 w_lineWords;
    logic                  w_hit;

    assign w_off       = r_addr[OFF_W-1:0];
    assign w_idx       = r_addr[OFF_W +: IDX_W];
    assign w_tag       = r_addr[ADDR_W-1 -: TAG_W];
    assign w_memWords  = mem_line;
    assign w_lineWords = r_dataArray[w_idx];
    assign w_hit       = r_valid[w_idx] && (r_tagArray[w_idx] == w_tag);

    // Line storage has no reset; only the valid vector decides what is usable.
    always_ff @(posedge clk) begin
        if (r_state == S_FILL && mem_ready) begin
            r_dataArray[w_idx] <= w_memWords;
            r_tagArray[w_idx]  <= w_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_addr     <= '0;
            r_fillWord <= '0;
            cpu_data   <= '0;
            cpu_ready  <= 1'b0;
            hit        <= 1'b0;
            busy       <= 1'b0;
            mem_read   <= 1'b0;
            mem_addr   <= '0;
        end else begin
            cpu_ready <= 1'b0;
            hit       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_valid <= '0;
                    end else if (cpu_read) begin
                        r_addr  <= cpu_addr;
                        busy    <= 1'b1;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        cpu_ready <= 1'b1;
                        hit       <= 1'b1;
                        cpu_data  <= w_lineWords[w_off];
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        mem_read <= 1'b1;
                        mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
                        r_state  <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (mem_ready) begin
                        r_valid[w_idx] <= 1'b1;
                        r_fillWord     <= w_memWords[w_off];
                        mem_read       <= 1'b0;
                        r_state        <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    cpu_ready <= 1'b1;
                    cpu_data  <= r_fillWord;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DM_CACHE_STATS_EN
    // Counters saturate rather than wrap so a long run never reports a small count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (r_state == S_IDLE && flush) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit && hit_count != 32'hFFFF_FFFF) begin
                hit_count <= hit_count + 32'd1;
            end else if (!w_hit && miss_count != 32'hFFFF_FFFF) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
